// File: rtl/drop_ctrl_pkg.sv
// Shared types and constants for the baggage drop sequencer.
package drop_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    DROP,
    REJECT,
    COOLDOWN
  } state_t;

  localparam logic [1:0] ST_NONE     = 2'b00;
  localparam logic [1:0] ST_DROPPED  = 2'b01;
  localparam logic [1:0] ST_REJECTED = 2'b10;
  localparam logic [1:0] ST_ABORTED  = 2'b11;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/drop_timer.sv
// Loadable down-counter that stops at zero; reused for settle, hold and cooldown.
module drop_timer #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/drop_controller.sv
// Baggage drop sequencer: request, settle check, actuator hold, cooldown.
// Optional outcome counters enabled with `DROP_CTRL_STATS_EN.
module drop_controller
  import drop_ctrl_pkg::*;
#(
  parameter int unsigned T_WIDTH         = 16,
  parameter int unsigned SETTLE_CYCLES   = 2,
  parameter int unsigned HOLD_CYCLES     = 8,
  parameter int unsigned COOLDOWN_CYCLES = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [T_WIDTH-1:0] t_act,
  input  logic [T_WIDTH-1:0] t_lim,
  input  logic               abort,
  output logic               drop_en,
  output logic               drop_activated,
  output logic               busy,
  output logic               done,
  output logic [1:0]         status
`ifdef DROP_CTRL_STATS_EN
  ,
  output logic [7:0]         drop_count,
  output logic [7:0]         reject_count,
  output logic [7:0]         abort_count
`endif
);

  localparam int unsigned CNT_MAX = max3(SETTLE_CYCLES, HOLD_CYCLES, COOLDOWN_CYCLES);
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);

  // The timer is loaded with N-1 so that 'zero' marks the last cycle of the state.
  localparam logic [CW-1:0] SETTLE_LD = CW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_LD   = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] COOL_LD   = CW'(COOLDOWN_CYCLES - 1);

  state_t          state;
  logic            pass;
  logic            accept;
  logic            abort_hit;
  logic            to_drop;
  logic            to_reject;
  logic            to_cool;
  logic            to_idle;
  logic            t_load;
  logic [CW-1:0]   t_val;
  logic            t_zero;
  logic [1:0]      cool_status;

  always_comb begin
    pass        = (t_act <= t_lim);
    accept      = (state == IDLE) && req_valid;
    abort_hit   = abort && ((state == CHECK) || (state == DROP));
    to_drop     = (state == CHECK) && !abort && pass && t_zero;
    to_reject   = (state == CHECK) && !abort && !pass;
    to_cool     = abort_hit || ((state == DROP) && t_zero) || (state == REJECT);
    to_idle     = (state == COOLDOWN) && t_zero;
    t_load      = accept || to_drop || to_cool;
    t_val       = '0;
    if (accept) begin
      t_val = SETTLE_LD;
    end else if (to_drop) begin
      t_val = HOLD_LD;
    end else if (to_cool) begin
      t_val = COOL_LD;
    end
    cool_status = ST_DROPPED;
    if (abort_hit) begin
      cool_status = ST_ABORTED;
    end else if (state == REJECT) begin
      cool_status = ST_REJECTED;
    end
  end

  drop_timer #(
    .W(CW)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .load    (t_load),
    .load_val(t_val),
    .zero    (t_zero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      req_ready      <= 1'b1;
      drop_en        <= 1'b0;
      drop_activated <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      status         <= ST_NONE;
    end else begin
      done <= 1'b0;
      if (accept) begin
        state     <= CHECK;
        req_ready <= 1'b0;
        busy      <= 1'b1;
        status    <= ST_NONE;
      end else if (to_drop) begin
        state          <= DROP;
        drop_en        <= 1'b1;
        drop_activated <= 1'b1;
      end else if (to_reject) begin
        state   <= REJECT;
        drop_en <= 1'b1;
      end else if (to_cool) begin
        state          <= COOLDOWN;
        drop_en        <= 1'b0;
        drop_activated <= 1'b0;
        done           <= 1'b1;
        status         <= cool_status;
      end else if (to_idle) begin
        state     <= IDLE;
        busy      <= 1'b0;
        req_ready <= 1'b1;
      end
    end
  end

`ifdef DROP_CTRL_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_count   <= '0;
      reject_count <= '0;
      abort_count  <= '0;
    end else if (to_cool) begin
      if (cool_status == ST_DROPPED && drop_count != '1) begin
        drop_count <= drop_count + 8'd1;
      end
      if (cool_status == ST_REJECTED && reject_count != '1) begin
        reject_count <= reject_count + 8'd1;
      end
      if (cool_status == ST_ABORTED && abort_count != '1) begin
        abort_count <= abort_count + 8'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_drop_controller.sv
// Self-checking bench for drop_controller: vector table, corner sequences, random requests.
module tb_drop_controller;

  localparam int S  = 2;
  localparam int H  = 8;
  localparam int CD = 4;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [15:0] t_act;
  logic [15:0] t_lim;
  logic        abort;
  logic        drop_en;
  logic        drop_activated;
  logic        busy;
  logic        done;
  logic [1:0]  status;
`ifdef DROP_CTRL_STATS_EN
  logic [7:0]  drop_count;
  logic [7:0]  reject_count;
  logic [7:0]  abort_count;
`endif

  drop_controller #(
    .T_WIDTH        (16),
    .SETTLE_CYCLES  (S),
    .HOLD_CYCLES    (H),
    .COOLDOWN_CYCLES(CD)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .t_act         (t_act),
    .t_lim         (t_lim),
    .abort         (abort),
    .drop_en       (drop_en),
    .drop_activated(drop_activated),
    .busy          (busy),
    .done          (done),
    .status        (status)
`ifdef DROP_CTRL_STATS_EN
    ,
    .drop_count    (drop_count),
    .reject_count  (reject_count),
    .abort_count   (abort_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Per-cycle stimulus of one request, indexed by cycle after the accept edge.
  logic [15:0] ta_v [1:31];
  logic [15:0] tl_v [1:31];
  logic        ab_v [1:31];
  logic        rv_v [1:31];
  int          got_done_cyc;
  logic [1:0]  got_status;

  typedef struct {
    logic [15:0] ta1;
    logic [15:0] ta2;
    logic [15:0] tl;
    int          ab_cyc;
    logic [1:0]  st;
    int          done_cyc;
  } vec_t;

  vec_t tbl [12];

  task automatic chk(input string name, input int cyc, input logic [31:0] got,
                     input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s (cycle %0d): got %0h, expected %0h", name, cyc, got, exp);
    end
  endtask

  task automatic fill_default();
    for (int c = 1; c <= 31; c++) begin
      ta_v[c] = 16'd100;
      tl_v[c] = 16'd120;
      ab_v[c] = 1'b0;
      rv_v[c] = 1'b0;
    end
  endtask

  task automatic wait_ready(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (req_ready) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Issues one request and checks every cycle against an outcome timeline
  // derived from the arrays: first abort/fail decides, otherwise a full hold.
  task automatic run_req();
    int         drop_lo, drop_hi, rej_cyc, c0, last;
    logic [1:0] st;
    bit         decided, ok;
    logic [4:0] exp_v, got_v;

    decided = 1'b0;
    drop_lo = 0;
    drop_hi = -1;
    rej_cyc = -1;
    c0      = 0;
    st      = 2'b00;
    for (int c = 1; c <= S; c++) begin
      if (!decided) begin
        if (ab_v[c]) begin
          c0 = c + 1; st = 2'b11; decided = 1'b1;
        end else if (ta_v[c] > tl_v[c]) begin
          rej_cyc = c + 1; c0 = c + 2; st = 2'b10; decided = 1'b1;
        end
      end
    end
    if (!decided) begin
      drop_lo = S + 1;
      drop_hi = S + H;
      c0      = S + H + 1;
      st      = 2'b01;
      for (int c = S + 1; c <= S + H; c++) begin
        if (ab_v[c] && st == 2'b01) begin
          drop_hi = c; c0 = c + 1; st = 2'b11;
        end
      end
    end
    last = c0 + CD;

    got_done_cyc = -1;
    got_status   = 2'bxx;
    wait_ready(ok);
    if (!ok) begin
      chk("req_ready_timeout", 0, 32'd0, 32'd1);
      return;
    end
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    for (int c = 1; c <= last; c++) begin
      t_act     = ta_v[c];
      t_lim     = tl_v[c];
      abort     = ab_v[c];
      req_valid = (c < last) ? rv_v[c] : 1'b0;
      @(negedge clk);
      exp_v = {(c >= last), (c < last),
               ((c >= drop_lo && c <= drop_hi) || c == rej_cyc),
               (c >= drop_lo && c <= drop_hi), (c == c0)};
      got_v = {req_ready, busy, drop_en, drop_activated, done};
      chk("ready_busy_en_act_done", c, 32'(got_v), 32'(exp_v));
      if (c >= c0) chk("status", c, 32'(status), 32'(st));
      if (done && got_done_cyc < 0) begin
        got_done_cyc = c;
        got_status   = status;
      end
      @(posedge clk);
      #1;
    end
    req_valid = 1'b0;
    abort     = 1'b0;
  endtask

  initial begin
    bit ok;
    rst = 1'b1; req_valid = 1'b0; abort = 1'b0; t_act = '0; t_lim = '0;
    repeat (2) @(negedge clk);
    chk("reset_outputs", 0, 32'({req_ready, busy, drop_en, drop_activated, done}), 32'b10000);
    chk("reset_status", 0, 32'(status), 32'd0);
    rst = 1'b0;

    // ta1, ta2, tl, abort cycle (0 = none), status, done cycle
    tbl[0]  = '{16'd100,    16'd100,    16'd120,    0,  2'b01, 11};
    tbl[1]  = '{16'd121,    16'd100,    16'd120,    0,  2'b10, 3};
    tbl[2]  = '{16'd120,    16'd130,    16'd120,    0,  2'b10, 4};
    tbl[3]  = '{16'd100,    16'd100,    16'd120,    5,  2'b11, 6};
    tbl[4]  = '{16'd100,    16'd100,    16'd120,    1,  2'b11, 2};
    tbl[5]  = '{16'hFFFF,   16'hFFFF,   16'hFFFF,   0,  2'b01, 11};
    tbl[6]  = '{16'h8000,   16'h8000,   16'h7FFF,   0,  2'b10, 3};
    tbl[7]  = '{16'd100,    16'd100,    16'd120,    10, 2'b11, 11};
    tbl[8]  = '{16'd100,    16'd130,    16'd120,    2,  2'b11, 3};
    tbl[9]  = '{16'd100,    16'd100,    16'd120,    2,  2'b11, 3};
    tbl[10] = '{16'd120,    16'd120,    16'd120,    0,  2'b01, 11};
    tbl[11] = '{16'd0,      16'd0,      16'd0,      0,  2'b01, 11};

    for (int i = 0; i < 12; i++) begin
      fill_default();
      for (int c = 1; c <= 31; c++) tl_v[c] = tbl[i].tl;
      ta_v[1] = tbl[i].ta1;
      ta_v[2] = tbl[i].ta2;
      if (tbl[i].ab_cyc > 0) ab_v[tbl[i].ab_cyc] = 1'b1;
      run_req();
      chk($sformatf("tbl%0d_done_cycle", i), i, 32'(got_done_cyc), 32'(tbl[i].done_cyc));
      chk($sformatf("tbl%0d_status", i), i, 32'(got_status), 32'(tbl[i].st));
    end

    // Abort while idle must not disturb anything.
    abort = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("idle_abort_outputs", i, 32'({req_ready, busy, drop_en, drop_activated, done}),
          32'b10000);
    end
    abort = 1'b0;
    fill_default();
    run_req();
    chk("after_idle_abort_status", 0, 32'(got_status), 32'd1);

    // Reset in the middle of the hold window.
    fill_default();
    wait_ready(ok);
    if (!ok) chk("req_ready_timeout", 0, 32'd0, 32'd1);
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0; t_act = 16'd100; t_lim = 16'd120;
    repeat (6) begin
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    chk("pre_reset_drop_activated", 7, 32'(drop_activated), 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("async_reset_outputs", 7, 32'({req_ready, busy, drop_en, drop_activated, done}),
        32'b10000);
    chk("async_reset_status", 7, 32'(status), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    fill_default();
    run_req();
    chk("post_reset_done_cycle", 0, 32'(got_done_cyc), 32'd11);
    chk("post_reset_status", 0, 32'(got_status), 32'd1);

    // Random requests against the timeline model.
    for (int n = 0; n < 150; n++) begin
      for (int c = 1; c <= 31; c++) begin
        tl_v[c] = 16'($urandom_range(65534, 1));
        if ($urandom_range(3, 0) != 0)
          ta_v[c] = 16'($urandom_range(32'(tl_v[c]), 0));
        else
          ta_v[c] = 16'($urandom_range(65535, 32'(tl_v[c]) + 1));
        ab_v[c] = ($urandom_range(11, 0) == 0);
        rv_v[c] = ($urandom_range(3, 0) == 0);
      end
      run_req();
    end

`ifdef DROP_CTRL_STATS_EN
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("stats_reset", 0, 32'({drop_count, reject_count, abort_count}), 32'd0);
    for (int n = 0; n < 300; n++) begin
      fill_default();
      run_req();
      if (n == 0) chk("drop_count_first", 0, 32'(drop_count), 32'd1);
    end
    chk("drop_count_sat", 0, 32'(drop_count), 32'd255);
    chk("reject_count", 0, 32'(reject_count), 32'd0);
    chk("abort_count", 0, 32'(abort_count), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
